// File: rtl/ipg_tx_arb.sv
// Two-requester IPG transmit arbiter: grants whole messages round-robin and
// forwards one chunk per offered TX slot through a single output register.
module ipg_tx_arb #(
   parameter int DATA_WIDTH = 64,
   parameter int MAX_CHUNKS = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] req0_chunk,
   input  logic                  req0_valid,
   input  logic                  req0_last,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req1_chunk,
   input  logic                  req1_valid,
   input  logic                  req1_last,
   output logic                  req1_ready,
   input  logic                  slot_avail,
   output logic [DATA_WIDTH-1:0] ipg_tx_chunk,
   output logic                  ipg_tx_valid,
   output logic                  grant_id,
   output logic                  busy,
   output logic                  trunc_err
);

   localparam int CNT_W = $clog2(MAX_CHUNKS) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CHUNKS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t                state_q;
   logic                  rr_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] tx_chunk_q;
   logic                  tx_valid_q;
   logic                  trunc_q;

   logic                  accept;
   logic                  acc_last;
   logic                  at_limit;
   logic [CNT_W-1:0]      cnt_d;
   logic [DATA_WIDTH-1:0] tx_chunk_d;

   // Only the owner of the slot stream can ever see ready; IDLE is the arbitration bubble.
   assign req0_ready = (state_q == GRANT0) & slot_avail & req0_valid;
   assign req1_ready = (state_q == GRANT1) & slot_avail & req1_valid;

   assign accept     = req0_ready | req1_ready;
   assign acc_last   = req1_ready ? req1_last : req0_last;
   assign tx_chunk_d = req1_ready ? req1_chunk : (req0_ready ? req0_chunk : '0);
   assign cnt_d      = cnt_q + CNT_W'(1);
   assign at_limit   = (cnt_d == CNT_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rr_q       <= 1'b0;
         cnt_q      <= '0;
         tx_valid_q <= 1'b0;
         tx_chunk_q <= '0;
         trunc_q    <= 1'b0;
      end else begin
         tx_valid_q <= accept;
         tx_chunk_q <= tx_chunk_d;
         trunc_q    <= accept & ~acc_last & at_limit;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               // rr only matters when both requesters contend
               if (req0_valid && !(req1_valid && rr_q)) begin
                  state_q <= GRANT0;
               end else if (req1_valid) begin
                  state_q <= GRANT1;
               end
            end
            GRANT0, GRANT1: begin
               if (accept) begin
                  if (acc_last || at_limit) begin
                     state_q <= IDLE;
                     rr_q    <= (state_q == GRANT0);
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ipg_tx_chunk = tx_chunk_q;
   assign ipg_tx_valid = tx_valid_q;
   assign trunc_err    = trunc_q;
   assign busy         = (state_q != IDLE);
   assign grant_id     = (state_q == GRANT1);

endmodule

// File: tb/tb_ipg_tx_arb.sv
// Bench for ipg_tx_arb: directed scenarios plus a randomized run, each cycle
// compared against a message-level model of ownership, chunk count and rr.
module tb_ipg_tx_arb;

   localparam int DW   = 64;
   localparam int MAXC = 16;

   logic          clk;
   logic          reset;
   logic [DW-1:0] req0_chunk, req1_chunk;
   logic          req0_valid, req1_valid, req0_last, req1_last;
   logic          req0_ready, req1_ready;
   logic          slot_avail;
   logic [DW-1:0] ipg_tx_chunk;
   logic          ipg_tx_valid, grant_id, busy, trunc_err;

   ipg_tx_arb #(.DATA_WIDTH(DW), .MAX_CHUNKS(MAXC)) dut (
      .clk          (clk),
      .reset        (reset),
      .req0_chunk   (req0_chunk),
      .req0_valid   (req0_valid),
      .req0_last    (req0_last),
      .req0_ready   (req0_ready),
      .req1_chunk   (req1_chunk),
      .req1_valid   (req1_valid),
      .req1_last    (req1_last),
      .req1_ready   (req1_ready),
      .slot_avail   (slot_avail),
      .ipg_tx_chunk (ipg_tx_chunk),
      .ipg_tx_valid (ipg_tx_valid),
      .grant_id     (grant_id),
      .busy         (busy),
      .trunc_err    (trunc_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Requester sources: pending chunks and their last flags, gated by g0/g1
   logic [DW-1:0] q0[$], q1[$];
   bit            q0l[$], q1l[$];
   bit            g0, g1;

   // Reference model: owner -1 = no message in progress
   int            m_owner;
   int            m_cnt;
   bit            m_rr;
   bit            e_txv, e_trunc;
   logic [DW-1:0] e_txc;

   function automatic bit mready(input int n);
      if (m_owner != n) return 1'b0;
      return (slot_avail === 1'b1) && ((n == 0) ? (req0_valid === 1'b1) : (req1_valid === 1'b1));
   endfunction

   task automatic add_msg(input int who, input int len, input bit with_last);
      for (int i = 0; i < len; i++) begin
         logic [DW-1:0] d;
         bit            l;
         d = {$urandom, $urandom};
         l = with_last && (i == len - 1);
         if (who == 0) begin
            q0.push_back(d); q0l.push_back(l);
         end else begin
            q1.push_back(d); q1l.push_back(l);
         end
      end
   endtask

   task automatic drive();
      req0_valid = g0 && (q0.size() > 0);
      req1_valid = g1 && (q1.size() > 0);
      if (req0_valid) begin
         req0_chunk = q0[0]; req0_last = q0l[0];
      end else begin
         req0_chunk = {$urandom, $urandom}; req0_last = 1'($urandom);
      end
      if (req1_valid) begin
         req1_chunk = q1[0]; req1_last = q1l[0];
      end else begin
         req1_chunk = {$urandom, $urandom}; req1_last = 1'($urandom);
      end
   endtask

   // Advance model by one clock using the inputs currently applied, then clock the DUT.
   task automatic tick();
      bit a0, a1, lst;
      a0 = mready(0);
      a1 = mready(1);
      e_txv = 1'b0; e_txc = '0; e_trunc = 1'b0;
      if (a0 || a1) begin
         e_txv = 1'b1;
         if (a1) begin
            e_txc = q1[0]; lst = q1l[0];
            void'(q1.pop_front()); void'(q1l.pop_front());
         end else begin
            e_txc = q0[0]; lst = q0l[0];
            void'(q0.pop_front()); void'(q0l.pop_front());
         end
         m_cnt++;
         if (lst || m_cnt == MAXC) begin
            e_trunc = !lst;
            m_rr    = (m_owner == 0);
            m_owner = -1;
            m_cnt   = 0;
         end
      end else if (m_owner < 0) begin
         m_cnt = 0;
         if (req0_valid && req1_valid) m_owner = m_rr ? 1 : 0;
         else if (req0_valid)          m_owner = 0;
         else if (req1_valid)          m_owner = 1;
      end
      if (reset) begin
         m_owner = -1; m_cnt = 0; m_rr = 1'b0;
         e_txv = 1'b0; e_txc = '0; e_trunc = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      q0.delete(); q0l.delete(); q1.delete(); q1l.delete();
      g0 = 1'b1; g1 = 1'b1; slot_avail = 1'b1;
      reset = 1'b1;
      drive(); #1; tick();
      drive(); #1; tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; g0 = 1'b1; g1 = 1'b1; slot_avail = 1'b1;
      add_msg(0, 3, 1'b1); add_msg(1, 3, 1'b1);
      for (int c = 0; c < 3; c++) begin
         drive(); #1; tick();
         checks++;
         if ({busy, grant_id, ipg_tx_valid, trunc_err, ipg_tx_chunk, req0_ready, req1_ready} !== '0)
            $display("FAIL reset_outputs: got busy=%b gid=%b v=%b te=%b chunk=%h r0=%b r1=%b, want all 0",
                     busy, grant_id, ipg_tx_valid, trunc_err, ipg_tx_chunk, req0_ready, req1_ready);
         if ({busy, grant_id, ipg_tx_valid, trunc_err, ipg_tx_chunk, req0_ready, req1_ready} !== '0)
            errors++;
      end
      reset = 1'b0;
      drive(); #1; tick();
      checks++;
      if ({busy, grant_id} !== 2'b10) begin
         errors++;
         $display("FAIL reset_first_arb: got busy=%b gid=%b, want busy=1 gid=0", busy, grant_id);
      end
   endtask

   task automatic test_single_msg();
      int mask, ntx;
      logic [DW-1:0] exp_c[$];
      do_reset();
      add_msg(0, 3, 1'b1);
      exp_c = q0;
      mask = 0; ntx = 0;
      for (int c = 0; c < 7; c++) begin
         drive(); #1;
         checks++;
         if ({req0_ready, req1_ready} !== {mready(0), mready(1)}) begin
            errors++;
            $display("FAIL single ready c%0d: got %b%b want %b%b", c, req0_ready, req1_ready, mready(0), mready(1));
         end
         if (req0_ready === 1'b1) mask |= (1 << c);
         tick();
         checks++;
         if ({busy, grant_id, ipg_tx_valid, trunc_err, ipg_tx_chunk} !== {m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc}) begin
            errors++;
            $display("FAIL single out c%0d: got %b%b%b%b %h want %b%b%b%b %h", c, busy, grant_id, ipg_tx_valid, trunc_err,
                     ipg_tx_chunk, m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc);
         end
         if (ipg_tx_valid === 1'b1) begin
            checks++;
            if (ntx >= 3 || ipg_tx_chunk !== exp_c[ntx]) begin
               errors++;
               $display("FAIL single order idx%0d: got %h", ntx, ipg_tx_chunk);
            end
            ntx++;
         end
      end
      checks++;
      if (mask !== 32'b1110 || ntx !== 3) begin
         errors++;
         $display("FAIL single timing: ready mask got %b want 1110, tx count got %0d want 3", mask, ntx);
      end
   endtask

   task automatic test_round_robin();
      int gseq[$];
      bit prev_busy;
      do_reset();
      add_msg(0, 2, 1'b1); add_msg(0, 2, 1'b1);
      add_msg(1, 2, 1'b1); add_msg(1, 2, 1'b1);
      prev_busy = 1'b0;
      for (int c = 0; c < 16; c++) begin
         drive(); #1;
         checks++;
         if ({req0_ready, req1_ready} !== {mready(0), mready(1)}) begin
            errors++;
            $display("FAIL rr ready c%0d: got %b%b want %b%b", c, req0_ready, req1_ready, mready(0), mready(1));
         end
         tick();
         checks++;
         if ({busy, grant_id, ipg_tx_valid, trunc_err, ipg_tx_chunk} !== {m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc}) begin
            errors++;
            $display("FAIL rr out c%0d: got %b%b%b%b %h want %b%b%b%b %h", c, busy, grant_id, ipg_tx_valid, trunc_err,
                     ipg_tx_chunk, m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc);
         end
         if (busy === 1'b1 && !prev_busy) gseq.push_back(int'(grant_id));
         prev_busy = (busy === 1'b1);
      end
      checks++;
      if (gseq.size() != 4 || gseq[0] != 0 || gseq[1] != 1 || gseq[2] != 0 || gseq[3] != 1) begin
         errors++;
         $display("FAIL rr order: got %0d grants %p want 0,1,0,1", gseq.size(), gseq);
      end
   endtask

   task automatic test_slot_gaps();
      bit slots[7] = '{1, 1, 0, 0, 1, 1, 1};
      int ntx;
      do_reset();
      add_msg(1, 3, 1'b1);
      ntx = 0;
      for (int c = 0; c < 7; c++) begin
         slot_avail = slots[c];
         drive(); #1;
         checks++;
         if ({req0_ready, req1_ready} !== {mready(0), mready(1)}) begin
            errors++;
            $display("FAIL gaps ready c%0d: got %b%b want %b%b", c, req0_ready, req1_ready, mready(0), mready(1));
         end
         tick();
         checks++;
         if ({busy, grant_id, ipg_tx_valid, trunc_err, ipg_tx_chunk} !== {m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc}) begin
            errors++;
            $display("FAIL gaps out c%0d: got %b%b%b%b %h want %b%b%b%b %h", c, busy, grant_id, ipg_tx_valid, trunc_err,
                     ipg_tx_chunk, m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc);
         end
         if (ipg_tx_valid === 1'b1) ntx++;
      end
      checks++;
      if (ntx != 3) begin
         errors++;
         $display("FAIL gaps count: got %0d chunks want 3", ntx);
      end
      slot_avail = 1'b1;
   endtask

   task automatic test_truncation();
      int tx_before, trunc_cnt, first_grant, tx_total;
      bit seen_trunc, prev_busy;
      do_reset();
      add_msg(0, 20, 1'b0);
      add_msg(1, 2, 1'b1);
      tx_before = 0; trunc_cnt = 0; first_grant = -1; tx_total = 0;
      seen_trunc = 1'b0; prev_busy = 1'b0;
      for (int c = 0; c < 30; c++) begin
         drive(); #1;
         checks++;
         if ({req0_ready, req1_ready} !== {mready(0), mready(1)}) begin
            errors++;
            $display("FAIL trunc ready c%0d: got %b%b want %b%b", c, req0_ready, req1_ready, mready(0), mready(1));
         end
         tick();
         checks++;
         if ({busy, grant_id, ipg_tx_valid, trunc_err, ipg_tx_chunk} !== {m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc}) begin
            errors++;
            $display("FAIL trunc out c%0d: got %b%b%b%b %h want %b%b%b%b %h", c, busy, grant_id, ipg_tx_valid, trunc_err,
                     ipg_tx_chunk, m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc);
         end
         if (ipg_tx_valid === 1'b1) tx_total++;
         if (ipg_tx_valid === 1'b1 && !seen_trunc) tx_before++;
         if (trunc_err === 1'b1) begin trunc_cnt++; seen_trunc = 1'b1; end
         if (seen_trunc && busy === 1'b1 && !prev_busy && first_grant < 0) first_grant = int'(grant_id);
         prev_busy = (busy === 1'b1);
      end
      checks++;
      if (trunc_cnt != 1 || tx_before != MAXC || first_grant != 1 || tx_total != 22) begin
         errors++;
         $display("FAIL trunc summary: pulses=%0d (1) chunks_before=%0d (16) next_grant=%0d (1) total=%0d (22)",
                  trunc_cnt, tx_before, first_grant, tx_total);
      end
   endtask

   task automatic test_reset_mid();
      int gseq[$];
      bit prev_busy;
      do_reset();
      add_msg(0, 4, 1'b1);
      add_msg(1, 2, 1'b1);
      g1 = 1'b0;
      prev_busy = 1'b0;
      for (int c = 0; c < 12; c++) begin
         reset = (c == 3);
         if (c == 3) g1 = 1'b1;
         drive(); #1;
         checks++;
         if ({req0_ready, req1_ready} !== {mready(0), mready(1)}) begin
            errors++;
            $display("FAIL rstmid ready c%0d: got %b%b want %b%b", c, req0_ready, req1_ready, mready(0), mready(1));
         end
         tick();
         checks++;
         if ({busy, grant_id, ipg_tx_valid, trunc_err, ipg_tx_chunk} !== {m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc}) begin
            errors++;
            $display("FAIL rstmid out c%0d: got %b%b%b%b %h want %b%b%b%b %h", c, busy, grant_id, ipg_tx_valid, trunc_err,
                     ipg_tx_chunk, m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc);
         end
         if (c == 3) begin
            checks++;
            if ({busy, grant_id, ipg_tx_valid, trunc_err, ipg_tx_chunk} !== '0) begin
               errors++;
               $display("FAIL rstmid cleared: got busy=%b gid=%b v=%b te=%b chunk=%h want all 0",
                        busy, grant_id, ipg_tx_valid, trunc_err, ipg_tx_chunk);
            end
         end
         if (busy === 1'b1 && !prev_busy) gseq.push_back(int'(grant_id));
         prev_busy = (busy === 1'b1);
      end
      reset = 1'b0;
      checks++;
      if (gseq.size() != 3 || gseq[0] != 0 || gseq[1] != 0 || gseq[2] != 1) begin
         errors++;
         $display("FAIL rstmid order: got %p want 0,0,1", gseq);
      end
      do_reset();
      add_msg(0, 1, 1'b1); add_msg(1, 1, 1'b1);
      g0 = 1'b0;
      drive(); #1; tick();
      checks++;
      if ({busy, grant_id} !== 2'b11) begin
         errors++;
         $display("FAIL rstmid req1_only: got busy=%b gid=%b want busy=1 gid=1", busy, grant_id);
      end
      g0 = 1'b1;
   endtask

   task automatic test_valid_drop();
      int r1_in_gap;
      do_reset();
      add_msg(0, 6, 1'b1);
      add_msg(1, 2, 1'b1);
      r1_in_gap = 0;
      for (int c = 0; c < 20; c++) begin
         g0 = !(c >= 3 && c < 8);
         drive(); #1;
         checks++;
         if ({req0_ready, req1_ready} !== {mready(0), mready(1)}) begin
            errors++;
            $display("FAIL vdrop ready c%0d: got %b%b want %b%b", c, req0_ready, req1_ready, mready(0), mready(1));
         end
         if (!g0 && (req1_ready !== 1'b0 || grant_id !== 1'b0)) r1_in_gap++;
         tick();
         checks++;
         if ({busy, grant_id, ipg_tx_valid, trunc_err, ipg_tx_chunk} !== {m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc}) begin
            errors++;
            $display("FAIL vdrop out c%0d: got %b%b%b%b %h want %b%b%b%b %h", c, busy, grant_id, ipg_tx_valid, trunc_err,
                     ipg_tx_chunk, m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc);
         end
      end
      checks++;
      if (r1_in_gap != 0) begin
         errors++;
         $display("FAIL vdrop gap: req1 ready or grant switch seen in %0d gap cycles, want 0", r1_in_gap);
      end
      g0 = 1'b1;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 800; c++) begin
         slot_avail = ($urandom_range(0, 3) != 0);
         g0 = ($urandom_range(0, 4) != 0);
         g1 = ($urandom_range(0, 4) != 0);
         reset = ($urandom_range(0, 149) == 0);
         if (q0.size() == 0 && $urandom_range(0, 3) == 0) add_msg(0, $urandom_range(1, 20), $urandom_range(0, 7) != 0);
         if (q1.size() == 0 && $urandom_range(0, 3) == 0) add_msg(1, $urandom_range(1, 20), $urandom_range(0, 7) != 0);
         drive(); #1;
         checks++;
         if ({req0_ready, req1_ready} !== {mready(0), mready(1)}) begin
            errors++;
            $display("FAIL rand ready c%0d: got %b%b want %b%b", c, req0_ready, req1_ready, mready(0), mready(1));
         end
         tick();
         checks++;
         if ({busy, grant_id, ipg_tx_valid, trunc_err, ipg_tx_chunk} !== {m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc}) begin
            errors++;
            $display("FAIL rand out c%0d: got %b%b%b%b %h want %b%b%b%b %h", c, busy, grant_id, ipg_tx_valid, trunc_err,
                     ipg_tx_chunk, m_owner >= 0, m_owner == 1, e_txv, e_trunc, e_txc);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; slot_avail = 1'b0; g0 = 1'b0; g1 = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_last = 1'b0; req1_last = 1'b0;
      req0_chunk = '0; req1_chunk = '0;
      m_owner = -1; m_cnt = 0; m_rr = 1'b0;
      e_txv = 1'b0; e_trunc = 1'b0; e_txc = '0;
      test_reset();
      test_single_msg();
      test_round_robin();
      test_slot_gaps();
      test_truncation();
      test_reset_mid();
      test_valid_drop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ipg_tx_arb.md
IPG_TX_ARB -- requirements
Module: ipg_tx_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of one IPG chunk (block-type byte in [7:0], payload in [63:8]).
REQ-002 Parameter MAX_CHUNKS, default 16, maximum chunks per message before forced termination.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 req0_chunk  input  DATA_WIDTH  chunk from requester 0 (memory-reply queue).
REQ-006 req0_valid  input  1  req0_chunk valid.
REQ-007 req0_last  input  1  req0_chunk is the final chunk of its message.
REQ-008 req0_ready  output  1  requester 0 chunk accepted this cycle.
REQ-009 req1_chunk / req1_valid / req1_last / req1_ready  same as REQ-005..008 for requester 1 (local request queue).
REQ-010 slot_avail  input  1  TX path offers one IPG slot this cycle.
REQ-011 ipg_tx_chunk  output  DATA_WIDTH  registered chunk to TX IPG insertion.
REQ-012 ipg_tx_valid  output  1  ipg_tx_chunk valid.
REQ-013 grant_id  output  1  requester currently owning the slot stream (meaningful when busy=1).
REQ-014 busy  output  1  a message is in progress.
REQ-015 trunc_err  output  1  one-cycle pulse: message forcibly terminated at MAX_CHUNKS.

Function
REQ-016 States SHALL be IDLE, GRANT0, GRANT1; busy=1 exactly in GRANT0/GRANT1; grant_id=0 in GRANT0, 1 in GRANT1, 0 in IDLE.
REQ-017 IDLE: if exactly one reqN_valid=1, next state GRANTN; if both, next state GRANT of requester indicated by round-robin pointer rr; if none, stay IDLE.
REQ-018 IDLE SHALL never assert any reqN_ready (one-cycle arbitration bubble per message).
REQ-019 reqN_ready SHALL equal (state==GRANTN) AND slot_avail AND reqN_valid, combinational; accept = reqN_ready.
REQ-020 Non-granted requester's ready SHALL be 0 regardless of inputs; messages are never interleaved.
REQ-021 On accept: next cycle ipg_tx_valid=1 and ipg_tx_chunk=accepted chunk (latency exactly 1); otherwise next cycle ipg_tx_valid=0 and ipg_tx_chunk=0.
REQ-022 Chunk counter cnt (width clog2(MAX_CHUNKS)+1) SHALL clear on entering GRANTx and increment per accept.
REQ-023 Accept with reqN_last=1 SHALL return to IDLE next cycle and set rr to the other requester.
REQ-024 Accept with last=0 where cnt+1==MAX_CHUNKS SHALL return to IDLE, set rr to other requester, pulse trunc_err next cycle; requester's further chunks of that message are treated as a new message.
REQ-025 In GRANTx with slot_avail=0 or reqx_valid=0: hold state, cnt, no output; no timeout other than REQ-024.
REQ-026 reqN_valid dropping while in GRANTN SHALL NOT release grant.
REQ-027 last=1 on the MAX_CHUNKS-th chunk SHALL be a normal end (no trunc_err).

Reset
REQ-028 reset=1 at any clock edge SHALL force state IDLE, rr=0, cnt=0, ipg_tx_valid=0, ipg_tx_chunk=0, trunc_err=0, busy=0, grant_id=0, both readys 0, including mid-message; partially sent message is abandoned without error.
REQ-029 First arbitration decision SHALL occur on the first edge after reset deasserts.

Verification
REQ-030 Single req0 message of 3 chunks (A,B,C, last on C), slot_avail=1 constant -> ready0 high cycles 2-4 after valid, ipg_tx_valid 3 consecutive cycles with A,B,C, busy deasserted one cycle after C accepted.
REQ-031 Both requesters valid from reset, 2-chunk messages each, repeated -> grant order 0,1,0,1; no interleaving; rr toggles after each last.
REQ-032 slot_avail pattern 1,0,0,1,1 during 3-chunk req1 message -> chunks emitted only in cycles following slot_avail=1; state held GRANT1 through gaps.
REQ-033 req0 sends 20 chunks with last never set, MAX_CHUNKS=16 -> 16 chunks output, trunc_err single pulse after 16th, grant passes to req1 if waiting, remaining 4 chunks sent as new message.
REQ-034 reset asserted after 2nd of 4 chunks -> next cycle all outputs zero, state IDLE, rr=0; after deassert, pending req1 (valid) granted before req0 only if req0 not valid.
REQ-035 req0 valid low for 5 cycles mid-message while req1 valid -> grant remains 0, ready1 stays 0 throughout.
